pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipelined MIPS core. It watches the IF/ID, ID/EX and EX/MEM pipeline registers and the data-memory ready line, then drives the write-enable and flush controls of the PC and every pipeline register. It handles three hazard classes: data-memory wait states (full freeze), taken branch/jump resolved in MEM (three-stage flush), and load-use hazards (one-cycle bubble). It also keeps hazard statistics and raises a sticky memory-timeout error.

## Interface
- CNT_W, 16, width of the saturating stall/flush statistic counters
- MEM_TIMEOUT, 16, consecutive freeze cycles after which mem_timeout sets (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- ifid_rs  in  5  rs field of the instruction in IF/ID
- ifid_rt  in  5  rt field of the instruction in IF/ID
- ifid_uses_rt  in  1  IF/ID instruction reads rt as a source
- idex_memread  in  1  ID/EX holds a load
- idex_rt  in  5  load destination register in ID/EX
- exmem_branch, exmem_zero, exmem_jump  in  1 each  EX/MEM Branch, zero and Jump bits
- exmem_memread, exmem_memwrite  in  1 each  EX/MEM memory access request
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register load enables
- pc_src  out  1  1 selects the EX/MEM branch/jump target for the PC
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all control bits 0)
- memwb_bubble  out  1  insert a bubble into MEM/WB
- state  out  2  FSM state: RUN=0, MEM_WAIT=1, FLUSH=2, STALL=3
- stall_cnt  out  CNT_W  cycles with any freeze or stall
- flush_cnt  out  CNT_W  taken-branch/jump flush events
- mem_timeout  out  1  sticky error flag

## Operation
- Derived terms:
  - taken = (exmem_branch & exmem_zero) | exmem_jump
  - mem_busy = (exmem_memread | exmem_memwrite) & ~dmem_ready
  - load_use = idex_memread & (idex_rt≠0) & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt))
- Priority, evaluated every cycle: mem_busy > taken > load_use > normal.
- mem_busy (freeze):
  - pc_write, ifid_write, idex_write and exmem_write all 0; memwb_bubble=1; no flushes.
  - Next state MEM_WAIT.
- taken:
  - pc_src=1, pc_write=1, ifid_flush=idex_flush=exmem_flush=1, remaining writes 1.
  - Next state FLUSH; flush_cnt+1.
- load_use:
  - pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1.
  - Next state STALL.
- Normal: all writes 1, flushes 0, pc_src 0, memwb_bubble 0; next state RUN.
- Per-state rules:
  - RUN and MEM_WAIT apply the full priority list.
  - FLUSH masks both taken and load_use, because bubbles now occupy the stages; mem_busy is still honoured.
  - STALL masks load_use only.
  - FLUSH and STALL each last exactly one cycle unless mem_busy redirects to MEM_WAIT.
- stall_cnt increments on every cycle with a mem_busy freeze or a load_use stall.
- Both statistic counters saturate at 2^CNT_W−1.
- Wait counter:
  - Counts consecutive mem_busy cycles and clears on any non-busy cycle.
  - When it reaches MEM_TIMEOUT, mem_timeout sets and stays 1 until rst.
  - Setting mem_timeout does not release the freeze.

## Timing
- Control outputs are combinational (Mealy) from the registered state and the current inputs, so the response is zero-latency and takes effect at the next clk edge.
- state, the counters, the wait counter and mem_timeout are registered.
- While rst=1:
  - All write enables are 0, all three flushes are 1, memwb_bubble=1, pc_src=0.
  - On the edge, state←RUN, counters←0, mem_timeout←0.
- First normal outputs appear in the cycle after rst drops.
- Reset asserted mid-freeze or mid-flush overrides everything in that same cycle.
- Freeze release: the cycle dmem_ready=1 arrives, mem_busy=0 and taken/load_use are evaluated in that same cycle.
- mem_busy together with taken: freeze wins. The branch stays held in EX/MEM and flushes on the release cycle.
- Saturated counters hold their value; they do not wrap.

## Test plan
- Reset: hold rst 2 cycles with random inputs → writes 0, flushes 1, state 0, stall_cnt=flush_cnt=0, mem_timeout=0.
- Load-use: idex_memread=1, idex_rt=10, ifid_rs=10 → pc_write=ifid_write=0, idex_flush=1 for one cycle; state 3 then 0; stall_cnt=1. Repeat with idex_rt=0 → no stall.
- Taken branch: exmem_branch=1, exmem_zero=1 → pc_src=1 and all three flushes 1 for one cycle; state 2; flush_cnt=1. Load_use asserted in the FLUSH cycle → ignored.
- Memory wait: exmem_memread=1, dmem_ready=0 for 5 cycles → all writes 0 for 5 cycles, state 1, stall_cnt=5. With taken also high → flush occurs only on the dmem_ready=1 cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 for 6 cycles → mem_timeout=1 from the 4th busy cycle and still 1 after ready returns; rst clears it.
- Saturation: CNT_W=3, 10 load-use stalls → stall_cnt stops at 7.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline.
// Mealy control outputs from the registered hazard state; registered statistics and timeout.
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             exmem_jump,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             pc_src,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    STALL    = 2'd3
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              taken, mem_busy, load_use;
  logic              stall_inc, flush_inc;

  assign taken    = (exmem_branch & exmem_zero) | exmem_jump;
  assign mem_busy = (exmem_memread | exmem_memwrite) & ~dmem_ready;
  assign load_use = idex_memread & (idex_rt != 5'd0) &
                    ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));
  assign state    = state_q;

  // FLUSH masks taken and load_use (bubbles fill the stages); STALL masks load_use only.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    pc_src       = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    state_d      = RUN;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = MEM_WAIT;
      stall_inc    = 1'b1;
    end else if (taken && state_q != FLUSH) begin
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = FLUSH;
      flush_inc   = 1'b1;
    end else if (load_use && (state_q == RUN || state_q == MEM_WAIT)) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_d    = STALL;
      stall_inc  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      // Wait counter saturates at the threshold so a long freeze cannot wrap it.
      if (mem_busy) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= WAIT_MAX - 1'b1) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl.
// Directed scenarios plus randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int CW   = 3;
  localparam int TOUT = 4;
  localparam int SAT  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic ifid_uses_rt, idex_memread;
  logic exmem_branch, exmem_zero, exmem_jump, exmem_memread, exmem_memwrite, dmem_ready;
  logic pc_write, ifid_write, idex_write, exmem_write, pc_src;
  logic ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_timeout;
  logic [1:0] state;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [17:0] obs, e;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state (mode uses the externally visible state numbering)
  int m_mode, m_stall, m_flush, m_run;
  logic m_tout;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero), .exmem_jump(exmem_jump),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .pc_src(pc_src),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  assign obs = {pc_write, ifid_write, idex_write, exmem_write, pc_src,
                ifid_flush, idex_flush, exmem_flush, memwb_bubble,
                state, stall_cnt, flush_cnt, mem_timeout};

  // 0 none, 1 freeze, 2 taken, 3 load-use -- the winning hazard this cycle
  function automatic int hazard();
    bit tk, bz, lu;
    tk = (exmem_branch && exmem_zero) || exmem_jump;
    bz = (exmem_memread || exmem_memwrite) && !dmem_ready;
    lu = idex_memread && idex_rt != 0 &&
         (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt));
    if (bz) return 1;
    if (tk && m_mode != 2) return 2;
    if (lu && (m_mode == 0 || m_mode == 1)) return 3;
    return 0;
  endfunction

  function automatic logic [17:0] model_exp();
    logic [3:0] w;
    logic [2:0] f;
    logic pcs, bub;
    w = 4'b1111; f = 3'b000; pcs = 1'b0; bub = 1'b0;
    if (rst) begin
      w = 4'b0000; f = 3'b111; bub = 1'b1;
    end else begin
      case (hazard())
        1: begin w = 4'b0000; bub = 1'b1; end
        2: begin pcs = 1'b1; f = 3'b111; end
        3: begin w = 4'b0011; f = 3'b010; end
        default: ;
      endcase
    end
    return {w, pcs, f, bub, 2'(m_mode), 3'(m_stall), 3'(m_flush), m_tout};
  endfunction

  task automatic model_step();
    int h;
    if (rst) begin
      m_mode = 0; m_stall = 0; m_flush = 0; m_run = 0; m_tout = 1'b0;
    end else begin
      h = hazard();
      m_mode = (h == 1) ? 1 : (h == 2) ? 2 : (h == 3) ? 3 : 0;
      if ((h == 1 || h == 3) && m_stall < SAT) m_stall++;
      if (h == 2 && m_flush < SAT) m_flush++;
      m_run = (h == 1) ? m_run + 1 : 0;
      if (m_run >= TOUT) m_tout = 1'b1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; ifid_rs = 5'd1; ifid_rt = 5'd2; ifid_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rt = 5'd0; exmem_branch = 1'b0; exmem_zero = 1'b0;
    exmem_jump = 1'b0; exmem_memread = 1'b0; exmem_memwrite = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      ifid_rs = 5'($urandom); ifid_rt = 5'($urandom); idex_rt = 5'($urandom);
      {ifid_uses_rt, idex_memread, exmem_branch, exmem_zero, exmem_jump,
       exmem_memread, exmem_memwrite, dmem_ready} = 8'($urandom);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs[17:9] !== 9'b0000_0111_1) begin
        n_fail++; $display("FAIL reset_ctrl obs=%b exp=%b", obs[17:9], 9'b000001111);
      end
      advance();
    end
    n_cmp++;
    if ({state, stall_cnt, flush_cnt, mem_timeout} !== 9'd0) begin
      n_fail++; $display("FAIL reset_regs obs=%b exp=0", {state, stall_cnt, flush_cnt, mem_timeout});
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      if (i < 2) begin idex_memread = 1'b1; idex_rt = 5'd10; ifid_rs = 5'd10; end
      #1; e = model_exp(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL load_use_c%0d obs=%h exp=%h", i, obs, e); end
      advance();
      n_cmp++;
      if (state !== ((i == 0) ? 2'd3 : 2'd0)) begin
        n_fail++; $display("FAIL load_use_state%0d obs=%0d", i, state);
      end
    end
    n_cmp++;
    if (stall_cnt !== 3'd1) begin n_fail++; $display("FAIL load_use_cnt obs=%0d exp=1", stall_cnt); end
    idle_inputs(); idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    #1; n_cmp++;
    if (pc_write !== 1'b1 || idex_flush !== 1'b0) begin
      n_fail++; $display("FAIL load_use_r0 obs=%b%b exp=10", pc_write, idex_flush);
    end
    advance();
  endtask

  task automatic test_taken();
    do_reset();
    idle_inputs(); exmem_branch = 1'b1; exmem_zero = 1'b1;
    #1; e = model_exp(); n_cmp++;
    if (obs !== e || {pc_src, ifid_flush, idex_flush, exmem_flush} !== 4'b1111) begin
      n_fail++; $display("FAIL taken obs=%h exp=%h", obs, e);
    end
    advance();
    idle_inputs(); idex_memread = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd7;
    #1; e = model_exp(); n_cmp++;
    if (obs !== e || state !== 2'd2 || pc_write !== 1'b1 || idex_flush !== 1'b0) begin
      n_fail++; $display("FAIL taken_mask obs=%h exp=%h", obs, e);
    end
    advance();
    n_cmp++;
    if (flush_cnt !== 3'd1 || state !== 2'd0) begin
      n_fail++; $display("FAIL taken_cnt obs=%0d/%0d exp=1/0", flush_cnt, state);
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle_inputs(); exmem_memread = 1'b1;
      dmem_ready = (i == 5 || i == 8);
      if (i >= 6) exmem_jump = 1'b1;
      #1; e = model_exp(); n_cmp++;
      if (obs !== e || pc_src !== (i == 8)) begin
        n_fail++; $display("FAIL mem_wait_c%0d obs=%h exp=%h", i, obs, e);
      end
      if (i == 4) begin
        n_cmp++;
        if (state !== 2'd1 || stall_cnt !== 3'd4) begin
          n_fail++; $display("FAIL mem_wait_mid obs=%0d/%0d exp=1/4", state, stall_cnt);
        end
      end
      advance();
    end
    n_cmp++;
    if (stall_cnt !== 3'd7 || flush_cnt !== 3'd1 || state !== 2'd2) begin
      n_fail++; $display("FAIL mem_wait_end obs=%0d/%0d/%0d exp=7/1/2", stall_cnt, flush_cnt, state);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle_inputs(); exmem_memwrite = 1'b1; dmem_ready = 1'b0;
      advance();
      n_cmp++;
      if (mem_timeout !== (i >= TOUT - 1)) begin
        n_fail++; $display("FAIL timeout_c%0d obs=%b exp=%b", i, mem_timeout, i >= TOUT - 1);
      end
    end
    idle_inputs(); exmem_memwrite = 1'b1;
    advance(); advance();
    n_cmp++;
    if (mem_timeout !== 1'b1 || state !== 2'd0) begin
      n_fail++; $display("FAIL timeout_sticky obs=%b/%0d exp=1/0", mem_timeout, state);
    end
    do_reset();
    n_cmp++;
    if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear obs=%b exp=0", mem_timeout); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle_inputs();
      if (i % 2 == 0) begin idex_memread = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9; ifid_uses_rt = 1'b1; end
      #1; e = model_exp(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL sat_c%0d obs=%h exp=%h", i, obs, e); end
      advance();
    end
    n_cmp++;
    if (stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_cnt obs=%0d exp=7", stall_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      ifid_rs = 5'($urandom_range(0, 3)); ifid_rt = 5'($urandom_range(0, 3));
      idex_rt = 5'($urandom_range(0, 3));
      ifid_uses_rt = 1'($urandom); idex_memread = 1'($urandom);
      exmem_branch = ($urandom_range(0, 3) == 0); exmem_zero = 1'($urandom);
      exmem_jump = ($urandom_range(0, 7) == 0);
      exmem_memread = ($urandom_range(0, 2) == 0); exmem_memwrite = ($urandom_range(0, 4) == 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      #1; e = model_exp(); n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL random_c%0d obs=%h exp=%h", i, obs, e); end
      advance();
    end
    idle_inputs();
  endtask

  initial begin
    m_mode = 0; m_stall = 0; m_flush = 0; m_run = 0; m_tout = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_taken();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
